// File: rtl/wb_arb_pkg.sv
// Shared definitions for the round-robin Wishbone arbiter: FSM encoding,
// timeout read-back pattern and per-master slice widths of the packed buses.
package wb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Same pattern the user bus returns for an unmapped address.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  localparam int SEL_W = 4;
  localparam int ADR_W = 32;
  localparam int DAT_W = 32;

  function automatic int idx_width(input int n_masters);
    return (n_masters > 2) ? 2 : 1;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) begin
        idx = 2'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between N Wishbone masters, the arbiter and the shared slave.
// slave modport = arbiter view, master modport = surrounding fabric view.
interface wb_rr_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int N_MASTERS = 2
);

  logic [N_MASTERS-1:0]       m_cyc_i;
  logic [N_MASTERS-1:0]       m_stb_i;
  logic [N_MASTERS-1:0]       m_we_i;
  logic [SEL_W*N_MASTERS-1:0] m_sel_i;
  logic [ADR_W*N_MASTERS-1:0] m_adr_i;
  logic [DAT_W*N_MASTERS-1:0] m_dat_i;
  logic [N_MASTERS-1:0]       m_ack_o;
  logic [DAT_W-1:0]           m_dat_o;

  logic                       s_cyc_o;
  logic                       s_stb_o;
  logic                       s_we_o;
  logic [SEL_W-1:0]           s_sel_o;
  logic [ADR_W-1:0]           s_adr_o;
  logic [DAT_W-1:0]           s_dat_o;
  logic                       s_ack_i;
  logic [DAT_W-1:0]           s_dat_i;

  logic [N_MASTERS-1:0]       grant_o;
  logic                       tmo_o;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    input  s_ack_i, s_dat_i,
    output m_ack_o, m_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output grant_o, tmo_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    output s_ack_i, s_dat_i,
    input  m_ack_o, m_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  grant_o, tmo_o
  );

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational round-robin pick: first requester above last_grant, wrapping,
// returned one-hot (all zero when nobody requests).
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int N_MASTERS = 2
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [N_MASTERS-1:0] last_grant,
  output logic [N_MASTERS-1:0] win
);

  localparam int IDX_W = idx_width(N_MASTERS);

  logic [IDX_W-1:0] last_idx_s;
  logic [IDX_W-1:0] cand_s;
  logic             found_s;

  // Scan offsets 1..N from the previous owner so it is considered last.
  always_comb begin
    last_idx_s = '0;
    cand_s     = '0;
    found_s    = 1'b0;
    win        = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (last_grant[i]) begin
        last_idx_s = IDX_W'(i);
      end else begin
        last_idx_s = last_idx_s;
      end
    end
    for (int off = 1; off <= N_MASTERS; off++) begin
      cand_s = IDX_W'((int'(last_idx_s) + off) % N_MASTERS);
      if (!found_s && req[cand_s]) begin
        win[cand_s] = 1'b1;
        found_s     = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave, a grant lasts a full
// cyc tenure. Optional stall timeout under `WB_RR_ARBITER_TIMEOUT_EN.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N_MASTERS   = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  wb_rr_arbiter_if.slave bus
);

  localparam int                   IDX_W    = idx_width(N_MASTERS);
  localparam logic [N_MASTERS-1:0] LAST_RST = {1'b1, {(N_MASTERS-1){1'b0}}};

  arb_state_e           state_r;
  arb_state_e           state_nxt_s;
  logic [N_MASTERS-1:0] grant_r;
  logic [N_MASTERS-1:0] grant_nxt_s;
  logic [N_MASTERS-1:0] last_r;
  logic [N_MASTERS-1:0] last_nxt_s;
  logic [N_MASTERS-1:0] win_s;
  logic [3:0]           grant_pad_s;
  logic [IDX_W-1:0]     own_idx_s;
  logic                 own_s;
  logic                 cyc_g_s;
  logic                 stb_g_s;
  logic                 tmo_hit_s;

  wb_rr_pick #(
    .N_MASTERS (N_MASTERS)
  ) u_pick (
    .req        (bus.m_cyc_i),
    .last_grant (last_r),
    .win        (win_s)
  );

  // Owner index and the owner's cyc/stb, forced low outside a tenure.
  always_comb begin
    grant_pad_s                = 4'd0;
    grant_pad_s[N_MASTERS-1:0] = grant_r;
    own_idx_s                  = IDX_W'(onehot_to_idx(grant_pad_s));
    own_s                      = (state_r == OWN);
    cyc_g_s                    = own_s & bus.m_cyc_i[own_idx_s];
    stb_g_s                    = own_s & bus.m_stb_i[own_idx_s];
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= IDLE;
      grant_r <= '0;
      last_r  <= LAST_RST;
    end else begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  // Next-state: grant on any cyc in IDLE, hold until the owner drops cyc.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    last_nxt_s  = last_r;
    case (state_r)
      IDLE: begin
        if (|bus.m_cyc_i) begin
          state_nxt_s = OWN;
          grant_nxt_s = win_s;
          last_nxt_s  = win_s;
        end else begin
          grant_nxt_s = '0;
        end
      end
      OWN: begin
        if (!cyc_g_s) begin
          state_nxt_s = IDLE;
          grant_nxt_s = '0;
        end else begin
          grant_nxt_s = grant_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        grant_nxt_s = '0;
      end
    endcase
  end

  // Slave-side mirror of the owner and ack/data steering back to it.
  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_sel_o = '0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.m_ack_o = '0;
    bus.m_dat_o = '0;
    if (own_s) begin
      bus.s_cyc_o = cyc_g_s;
      bus.s_stb_o = stb_g_s & ~tmo_hit_s;
      bus.s_we_o  = bus.m_we_i[own_idx_s];
      bus.s_sel_o = bus.m_sel_i[own_idx_s*SEL_W +: SEL_W];
      bus.s_adr_o = bus.m_adr_i[own_idx_s*ADR_W +: ADR_W];
      bus.s_dat_o = bus.m_dat_i[own_idx_s*DAT_W +: DAT_W];
      bus.m_ack_o = grant_r & {N_MASTERS{bus.s_ack_i | tmo_hit_s}};
      bus.m_dat_o = tmo_hit_s ? TIMEOUT_DATA : bus.s_dat_i;
    end else begin
      bus.m_dat_o = '0;
    end
  end

  assign bus.grant_o = grant_r;

`ifdef WB_RR_ARBITER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] stall_cnt_r;
  logic       tmo_r;

  // Fires on the TIMEOUT_CYC-th consecutive unacked strobe cycle.
  assign tmo_hit_s = stb_g_s & ~bus.s_ack_i & (stall_cnt_r == TMO_LAST);

  // Stall counter and sticky timeout flag.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stall_cnt_r <= 8'd0;
      tmo_r       <= 1'b0;
    end else begin
      if (!own_s || bus.s_ack_i || tmo_hit_s) begin
        stall_cnt_r <= 8'd0;
      end else if (stb_g_s) begin
        stall_cnt_r <= stall_cnt_r + 8'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      tmo_r <= tmo_r | tmo_hit_s;
    end
  end

  assign bus.tmo_o = tmo_r;
`else
  assign tmo_hit_s = 1'b0;
  assign bus.tmo_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter: directed master transactions push expected
// acks and grants; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_wb_rr_arbiter;

  localparam int          N    = 2;
  localparam logic [31:0] DEAD = 32'hDEADBEEF;

  typedef struct {
    logic [31:0] ack;
    logic [31:0] rdat;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] we;
    logic [31:0] sel;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cyc_m [N];
  logic        stb_m [N];
  logic        we_m  [N];
  logic [3:0]  sel_m [N];
  logic [31:0] adr_m [N];
  logic [31:0] dat_m [N];
  logic        slave_en;
  logic [31:0] slave_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t        ack_q[$];
  logic [31:0] grant_q[$];
  logic [N-1:0] prev_grant = '0;

  wb_rr_arbiter_if #(.N_MASTERS(N)) bus ();

  wb_rr_arbiter #(
    .N_MASTERS   (N),
    .TIMEOUT_CYC (4)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus.slave)
  );

  assign bus.m_cyc_i = {cyc_m[1], cyc_m[0]};
  assign bus.m_stb_i = {stb_m[1], stb_m[0]};
  assign bus.m_we_i  = {we_m[1], we_m[0]};
  assign bus.m_sel_i = {sel_m[1], sel_m[0]};
  assign bus.m_adr_i = {adr_m[1], adr_m[0]};
  assign bus.m_dat_i = {dat_m[1], dat_m[0]};
  assign bus.s_ack_i = slave_en & bus.s_cyc_o & bus.s_stb_o;
  assign bus.s_dat_i = slave_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_ack(input int k, input logic [31:0] rdat, input logic [31:0] adr,
                          input logic [31:0] wdat, input logic we, input logic [3:0] sel);
    exp_t e;
    e.ack  = 32'd1 << k;
    e.rdat = rdat;
    e.adr  = adr;
    e.wdat = wdat;
    e.we   = {31'd0, we};
    e.sel  = {28'd0, sel};
    ack_q.push_back(e);
  endtask

  // Monitor: every ack and every new tenure is checked against the queues.
  always @(negedge clk) begin
    exp_t e;
    if (bus.m_ack_o != '0) begin
      if (ack_q.size() == 0) begin
        check("unexpected_ack", 32'(bus.m_ack_o), 32'd0);
      end else begin
        e = ack_q.pop_front();
        check("ack_vec", 32'(bus.m_ack_o), e.ack);
        check("rdata", bus.m_dat_o, e.rdat);
        check("s_adr", bus.s_adr_o, e.adr);
        check("s_wdat", bus.s_dat_o, e.wdat);
        check("s_we", 32'(bus.s_we_o), e.we);
        check("s_sel", 32'(bus.s_sel_o), e.sel);
      end
    end
    if (bus.grant_o != prev_grant && bus.grant_o != '0) begin
      check("dead_cycle_before_grant", 32'(prev_grant), 32'd0);
      if (grant_q.size() == 0) check("unexpected_grant", 32'(bus.grant_o), 32'd0);
      else check("grant_seq", 32'(bus.grant_o), grant_q.pop_front());
    end
    prev_grant = bus.grant_o;
  end

  task automatic wait_ack(input int k);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 64 && !seen; c++) begin
      @(negedge clk);
      if (bus.m_ack_o[k]) seen = 1'b1;
    end
    check($sformatf("ack_seen_m%0d", k), 32'(seen), 32'd1);
    @(posedge clk); #1;
    cyc_m[k] = 1'b0;
    stb_m[k] = 1'b0;
    we_m[k]  = 1'b0;
  endtask

  task automatic master_xfer(input int k, input logic we, input logic [31:0] adr,
                             input logic [31:0] wdat, input logic [3:0] sel);
    @(posedge clk); #1;
    cyc_m[k] = 1'b1;
    stb_m[k] = 1'b1;
    we_m[k]  = we;
    adr_m[k] = adr;
    dat_m[k] = wdat;
    sel_m[k] = sel;
    wait_ack(k);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int stall;
    int hit_at;
    for (int k = 0; k < N; k++) begin
      cyc_m[k] = 1'b0; stb_m[k] = 1'b0; we_m[k] = 1'b0;
      sel_m[k] = 4'h0; adr_m[k] = 32'h0; dat_m[k] = 32'h0;
    end
    adr_m[0]    = 32'hCAFE_0000;
    slave_en    = 1'b0;
    slave_rdata = 32'h5555_AAAA;

    // Reset state, idle outputs must not leak master or slave values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 32'(bus.grant_o), 32'd0);
    check("rst_tmo", 32'(bus.tmo_o), 32'd0);
    check("rst_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    check("rst_s_adr", bus.s_adr_o, 32'd0);
    check("rst_m_ack", 32'(bus.m_ack_o), 32'd0);
    check("rst_m_dat", bus.m_dat_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single master write with latency/release checks.
    slave_en    = 1'b1;
    slave_rdata = 32'h0000_0000;
    grant_q.push_back(32'h1);
    push_ack(0, 32'h0, 32'h0002_0010, 32'h1234_5678, 1'b1, 4'hF);
    fork
      master_xfer(0, 1'b1, 32'h0002_0010, 32'h1234_5678, 4'hF);
      begin
        @(posedge clk);
        @(negedge clk);
        check("lat_s_cyc_before", 32'(bus.s_cyc_o), 32'd0);
        check("lat_grant_before", 32'(bus.grant_o), 32'd0);
        @(negedge clk);
        check("lat_s_cyc_after", 32'(bus.s_cyc_o), 32'd1);
        check("lat_grant_after", 32'(bus.grant_o), 32'h1);
        @(negedge clk);
        check("grant_hold_drop_cycle", 32'(bus.grant_o), 32'h1);
        check("s_cyc_mirror_drop", 32'(bus.s_cyc_o), 32'd0);
        @(negedge clk);
        check("grant_release", 32'(bus.grant_o), 32'd0);
      end
    join

    // Simultaneous requests straight after reset: master0 first.
    do_reset();
    slave_rdata = 32'h1111_0000;
    grant_q.push_back(32'h1);
    grant_q.push_back(32'h2);
    push_ack(0, 32'h1111_0000, 32'h0000_0100, 32'hAAAA_0000, 1'b1, 4'h3);
    push_ack(1, 32'h1111_0000, 32'h0000_0200, 32'hBBBB_0000, 1'b1, 4'hC);
    fork
      master_xfer(0, 1'b1, 32'h0000_0100, 32'hAAAA_0000, 4'h3);
      master_xfer(1, 1'b1, 32'h0000_0200, 32'hBBBB_0000, 4'hC);
    join

    // Fairness: both request continuously for six tenures.
    for (int i = 0; i < 3; i++) begin
      grant_q.push_back(32'h1);
      grant_q.push_back(32'h2);
      push_ack(0, 32'h1111_0000, 32'h0000_1000 + 32'(i), 32'h0, 1'b0, 4'hF);
      push_ack(1, 32'h1111_0000, 32'h0000_2000 + 32'(i), 32'h0, 1'b0, 4'hF);
    end
    fork
      for (int i = 0; i < 3; i++) master_xfer(0, 1'b0, 32'h0000_1000 + 32'(i), 32'h0, 4'hF);
      for (int j = 0; j < 3; j++) master_xfer(1, 1'b0, 32'h0000_2000 + 32'(j), 32'h0, 4'hF);
    join

    // Read by master1 with broadcast read data.
    slave_rdata = 32'hA5A5_0001;
    grant_q.push_back(32'h2);
    push_ack(1, 32'hA5A5_0001, 32'h0001_0000, 32'h0, 1'b0, 4'hF);
    master_xfer(1, 1'b0, 32'h0001_0000, 32'h0, 4'hF);

    // cyc without stb still releases the grant.
    grant_q.push_back(32'h1);
    @(posedge clk); #1;
    cyc_m[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("nostb_grant", 32'(bus.grant_o), 32'h1);
    check("nostb_s_stb", 32'(bus.s_stb_o), 32'd0);
    @(posedge clk); #1;
    cyc_m[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("nostb_release", 32'(bus.grant_o), 32'd0);

    // Reset in the middle of a stalled tenure.
    slave_en    = 1'b0;
    slave_rdata = 32'h7777_0000;
    grant_q.push_back(32'h1);
    @(posedge clk); #1;
    cyc_m[0] = 1'b1; stb_m[0] = 1'b1; adr_m[0] = 32'h0000_3000; sel_m[0] = 4'hF;
    @(negedge clk);
    @(negedge clk);
    check("midrst_grant_before", 32'(bus.grant_o), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    check("midrst_grant", 32'(bus.grant_o), 32'd0);
    check("midrst_m_ack", 32'(bus.m_ack_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc_m[1] = 1'b1; stb_m[1] = 1'b1; adr_m[1] = 32'h0000_4000; sel_m[1] = 4'h1;
    grant_q.push_back(32'h1);
    grant_q.push_back(32'h2);
    push_ack(0, 32'h7777_0000, 32'h0000_3000, 32'h0, 1'b0, 4'hF);
    push_ack(1, 32'h7777_0000, 32'h0000_4000, 32'h0, 1'b0, 4'h1);
    @(negedge clk);
    @(negedge clk);
    check("post_rst_first_owner", 32'(bus.grant_o), 32'h1);
    @(posedge clk); #1;
    slave_en = 1'b1;
    wait_ack(0);
    wait_ack(1);

    // Stall timeout: slave never acks.
    slave_en = 1'b0;
    grant_q.push_back(32'h1);
`ifdef WB_RR_ARBITER_TIMEOUT_EN
    push_ack(0, DEAD, 32'h0000_5000, 32'h0, 1'b0, 4'hF);
`endif
    @(posedge clk); #1;
    cyc_m[0] = 1'b1; stb_m[0] = 1'b1; adr_m[0] = 32'h0000_5000; sel_m[0] = 4'hF;
    stall  = 0;
    hit_at = 0;
    for (int c = 0; c < 12 && hit_at == 0; c++) begin
      @(negedge clk);
      if (bus.grant_o != '0) stall++;
      if (stall == 3) check("tmo_flag_early", 32'(bus.tmo_o), 32'd0);
      if (bus.m_ack_o[0]) begin
        hit_at = stall;
        check("tmo_s_stb_forced", 32'(bus.s_stb_o), 32'd0);
      end
    end
`ifdef WB_RR_ARBITER_TIMEOUT_EN
    check("tmo_ack_cycle", 32'(hit_at), 32'd4);
`else
    check("no_tmo_ack", 32'(hit_at), 32'd0);
`endif
    @(posedge clk); #1;
    cyc_m[0] = 1'b0; stb_m[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
`ifdef WB_RR_ARBITER_TIMEOUT_EN
      check("tmo_sticky", 32'(bus.tmo_o), 32'd1);
`else
      check("tmo_tied_low", 32'(bus.tmo_o), 32'd0);
`endif
    end

    repeat (3) @(negedge clk);
    check("ack_q_empty", 32'(ack_q.size()), 32'd0);
    check("grant_q_empty", 32'(grant_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone arbiter that lets N_MASTERS bus masters share one Wishbone slave port, i.e. the user_project peripheral bus (TMR32/PWM, UART, SRAM wrapper).
- Typical masters: the management-core Wishbone port plus a UART-to-SRAM DMA engine.
- A grant lasts for a whole bus tenure: from the first cycle the granted master asserts cyc until it drops cyc.
- Read data is broadcast to all masters; ack is steered only to the granted master.

Parameters:
- N_MASTERS, 2: number of requesters. Legal range 2..4.
- TIMEOUT_CYC, 255: stall limit in cycles for the optional timeout (8-bit counter). Legal range 1..255.

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_i  in  1  synchronous active-high reset
- m_cyc_i  in  N_MASTERS  per-master cyc
- m_stb_i  in  N_MASTERS  per-master stb
- m_we_i  in  N_MASTERS  per-master we
- m_sel_i  in  4*N_MASTERS  byte selects, master k at bits [4k+3:4k]
- m_adr_i  in  32*N_MASTERS  addresses, packed the same way
- m_dat_i  in  32*N_MASTERS  write data, packed the same way
- m_ack_o  out  N_MASTERS  per-master ack
- m_dat_o  out  32  read data, shared by all masters
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side strobes
- s_sel_o  out  4  slave byte selects
- s_adr_o  out  32  slave address
- s_dat_o  out  32  slave write data
- s_ack_i  in  1  slave ack
- s_dat_i  in  32  slave read data
- grant_o  out  N_MASTERS  one-hot current owner (0 = bus idle)
- tmo_o  out  1  sticky timeout flag

Behaviour:
- Reset (synchronous): state=IDLE, grant_o=0, last_grant=N_MASTERS-1 so master 0 has first priority, tmo_o=0.
- Outputs while grant_o=0: all s_* outputs 0, m_ack_o=0, m_dat_o=0.
- FSM states: IDLE, OWN.
- IDLE:
  - If any m_cyc_i is high, pick the first requester scanning upward from last_grant+1, wrapping modulo N_MASTERS.
  - Register the winner into grant_o and last_grant, then go to OWN.
  - Arbitration latency is exactly 1 cycle: the slave sees the winner's cyc/stb on the cycle after the request is first seen in IDLE.
- OWN:
  - s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o mirror the granted master combinationally.
  - m_ack_o[g] = s_ack_i; m_dat_o = s_dat_i. Other masters' ack is held at 0.
  - When the granted master's m_cyc_i is low, go to IDLE. grant_o clears next cycle, so there is always at least one dead cycle between tenures.
  - Requests from other masters are ignored during OWN. There is no preemption.
- Simultaneous requests: the round-robin pointer guarantees each waiting master is granted within N_MASTERS tenures.
- The same master re-requesting immediately wins only when no other master is requesting.
- If s_ack_i arrives on the same cycle cyc drops, the ack is still forwarded to the granted master.
- A master dropping cyc without ever asserting stb releases the grant normally.
- Reset asserted mid-tenure: the grant is dropped on the next edge and s_cyc_o goes low. The owning master sees no ack.

Optional Feature:
- Macro: WB_RR_ARBITER_TIMEOUT_EN.
- Enabled:
  - An 8-bit counter increments in OWN while s_stb_o=1 and s_ack_i=0, and clears on ack or on leaving OWN.
  - When the count reaches TIMEOUT_CYC, the arbiter on that cycle drives m_ack_o[g]=1 with m_dat_o=32'hDEADBEEF and forces s_stb_o=0. It also sets tmo_o, which stays set until reset.
- Disabled: no counter is built, tmo_o is tied to 0, and the arbiter waits indefinitely for ack.

Decomposition:
- Shared package wb_arb_pkg holds:
  - FSM state encoding: IDLE=1'b0, OWN=1'b1.
  - TIMEOUT_DATA = 32'hDEADBEEF, which matches the invalid-address read data already used on the user bus.
  - The packed-slice width constants: 4 bits per master for sel, 32 bits per master for adr and dat.
- One natural sub-module: wb_rr_pick. It is purely combinational: inputs request vector and last_grant, output the one-hot winner. It is unit-testable on its own.
- The address/data mux stays inline in the top module.

Test Plan:
- Single master: master0 writes 32'h12345678 to 0x0002_0010. Expect s_cyc_o rising 1 cycle after m_cyc_i[0] and grant_o=2'b01. The slave ack reaches m_ack_o[0] in the same cycle; grant_o returns to 0 one cycle after cyc drops.
- Simultaneous requests: both masters raise cyc in the same cycle immediately after reset. Expect master0 to get the first tenure and master1 the next (grant_o 01→00→10), with master1's ack held at 0 throughout master0's tenure.
- Fairness: both masters request continuously for 6 tenures. Expect the grant sequence 0,1,0,1,0,1 with no master served twice in a row.
- Read data: master1 reads from 0x0001_0000 while the slave returns 32'hA5A5_0001. Expect m_dat_o=32'hA5A5_0001 with m_ack_o=2'b10.
- Reset mid-tenure: assert wb_rst_i while master0 owns the bus with stb high. Expect s_cyc_o=0, grant_o=0 and m_ack_o=0 on the next edge; after release, master0 wins first.
- Timeout (macro on, TIMEOUT_CYC=4): master0 strobes and the slave never acks. Expect m_ack_o[0]=1 with m_dat_o=32'hDEADBEEF at the 4th stall cycle, and tmo_o=1 sticky. With the macro off, tmo_o stays 0 and no ack is generated.
